// File: rtl/sifre_cozme_modulu.sv
// rtl/sifre_cozme_modulu.sv - AES-128 iterative inverse cipher, one round per clock
// Composite-field GF((2^4)^2) S-boxes; key schedule expanded forward then unwound per round.
module sifre_cozme_modulu (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] cipher_in,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] plain_out
);

    typedef enum logic [1:0] {IDLE = 2'd0, KEYEXP = 2'd1, ROUND = 2'd2} state_t;

    state_t       r_fsm;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [127:0] r_plain;
    logic [3:0]   r_rcnt;
    logic         r_busy;
    logic         r_done;

    function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
        return {(a[1] & b[1]) ^ (a[0] & b[1]) ^ (a[1] & b[0]), (a[1] & b[1]) ^ (a[0] & b[0])};
    endfunction

    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] hh, ll, mm;
        hh = gf2_mul(a[3:2], b[3:2]);
        ll = gf2_mul(a[1:0], b[1:0]);
        mm = gf2_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]);
        return {mm ^ ll, {hh[1] ^ hh[0], hh[1]} ^ ll};
    endfunction

    function automatic logic [3:0] gf4_inv(input logic [3:0] q);
        logic x3, x2, x1, x0;
        x3 = q[3] ^ (q[3] & q[2] & q[1]) ^ (q[3] & q[0]) ^ q[2];
        x2 = (q[3] & q[2] & q[1]) ^ (q[3] & q[2] & q[0]) ^ (q[3] & q[0]) ^ q[2] ^ (q[2] & q[1]);
        x1 = q[3] ^ (q[3] & q[2] & q[1]) ^ (q[3] & q[1] & q[0]) ^ q[2] ^ (q[2] & q[0]) ^ q[1];
        x0 = (q[3] & q[2] & q[1]) ^ (q[3] & q[2] & q[0]) ^ (q[3] & q[1]) ^ (q[3] & q[1] & q[0])
           ^ (q[3] & q[0]) ^ q[2] ^ (q[2] & q[1]) ^ (q[2] & q[1] & q[0]) ^ q[1] ^ q[0];
        return {x3, x2, x1, x0};
    endfunction

    // Inversion in the composite field: map in, invert via GF(2^4) norm, map back.
    function automatic logic [7:0] gf8_inv(input logic [7:0] q);
        logic [7:0] m, r;
        logic [3:0] ah, al, sq, d, di;
        m[7] = q[7] ^ q[5];
        m[6] = q[7] ^ q[6] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
        m[5] = q[7] ^ q[5] ^ q[3] ^ q[2];
        m[4] = q[7] ^ q[5] ^ q[3] ^ q[2] ^ q[1];
        m[3] = q[7] ^ q[6] ^ q[2] ^ q[1];
        m[2] = q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
        m[1] = q[6] ^ q[4] ^ q[1];
        m[0] = q[6] ^ q[1] ^ q[0];
        ah = m[7:4];
        al = m[3:0];
        sq = {ah[3], ah[3] ^ ah[2], ah[2] ^ ah[1], ah[3] ^ ah[1] ^ ah[0]};
        d  = {sq[2] ^ sq[0], sq[3] ^ sq[2] ^ sq[1] ^ sq[0], sq[3], sq[2]} ^ gf4_mul(ah ^ al, al);
        di = gf4_inv(d);
        m  = {gf4_mul(ah, di), gf4_mul(ah ^ al, di)};
        r[7] = m[7] ^ m[6] ^ m[5] ^ m[1];
        r[6] = m[6] ^ m[2];
        r[5] = m[6] ^ m[5] ^ m[1];
        r[4] = m[6] ^ m[5] ^ m[4] ^ m[2] ^ m[1];
        r[3] = m[5] ^ m[4] ^ m[3] ^ m[2] ^ m[1];
        r[2] = m[7] ^ m[4] ^ m[3] ^ m[2] ^ m[1];
        r[1] = m[5] ^ m[4];
        r[0] = m[6] ^ m[5] ^ m[4] ^ m[2] ^ m[0];
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf8_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf8_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [31:0]  w_sub_in, w_sub_word, w_rcon_word;
    logic [31:0]  w_f0, w_f1, w_f2, w_f3;
    logic [127:0] w_key_fwd, w_key_inv;
    logic [127:0] w_isr, w_isb, w_ark, w_mix, w_round_out;

    // Four S-boxes shared: forward step uses w3, inverse step uses w3^w2 (the recovered w3).
    assign w_sub_in    = (r_fsm == ROUND) ? (r_key[31:0] ^ r_key[63:32]) : r_key[31:0];
    assign w_sub_word  = {sbox(w_sub_in[23:16]), sbox(w_sub_in[15:8]),
                          sbox(w_sub_in[7:0]), sbox(w_sub_in[31:24])};
    assign w_rcon_word = {rcon(r_rcnt), 24'h000000};

    assign w_f0      = r_key[127:96] ^ w_sub_word ^ w_rcon_word;
    assign w_f1      = r_key[95:64] ^ w_f0;
    assign w_f2      = r_key[63:32] ^ w_f1;
    assign w_f3      = r_key[31:0] ^ w_f2;
    assign w_key_fwd = {w_f0, w_f1, w_f2, w_f3};
    assign w_key_inv = {r_key[127:96] ^ w_sub_word ^ w_rcon_word, r_key[127:96] ^ r_key[95:64],
                        r_key[95:64] ^ r_key[63:32], r_key[63:32] ^ r_key[31:0]};

    always_comb begin
        w_isr = '0;
        w_isb = '0;
        w_mix = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_isr[127 - 8 * (4 * c + r) -: 8] = r_state[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        for (int k = 0; k < 16; k++) begin
            w_isb[127 - 8 * k -: 8] = inv_sbox(w_isr[127 - 8 * k -: 8]);
        end
        w_ark = w_isb ^ w_key_inv;
        for (int c = 0; c < 4; c++) begin
            w_mix[127 - 32 * c -: 32] = inv_mix_col(w_ark[127 - 32 * c -: 32]);
        end
        w_round_out = (r_rcnt == 4'd0) ? w_ark : w_mix;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm   <= IDLE;
            r_state <= '0;
            r_key   <= '0;
            r_plain <= '0;
            r_rcnt  <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                IDLE: begin
                    if (start) begin
                        r_state <= cipher_in;
                        r_key   <= key_in;
                        r_rcnt  <= 4'd0;
                        r_busy  <= 1'b1;
                        r_fsm   <= KEYEXP;
                    end
                end
                KEYEXP: begin
                    r_key <= w_key_fwd;
                    if (r_rcnt == 4'd9) begin
                        r_state <= r_state ^ w_key_fwd;
                        r_fsm   <= ROUND;
                    end else begin
                        r_rcnt <= r_rcnt + 4'd1;
                    end
                end
                ROUND: begin
                    r_key   <= w_key_inv;
                    r_state <= w_round_out;
                    if (r_rcnt == 4'd0) begin
                        r_plain <= w_round_out;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_fsm   <= IDLE;
                    end else begin
                        r_rcnt <= r_rcnt - 4'd1;
                    end
                end
                default: begin
                    r_fsm  <= IDLE;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign plain_out = r_plain;

endmodule

// File: tb/tb_sifre_cozme_modulu.sv
// tb/tb_sifre_cozme_modulu.sv - self-checking bench for the AES-128 inverse cipher block
// Reference: table-built S-boxes and a textbook FIPS-197 key expansion / inverse cipher.
module tb_sifre_cozme_modulu;

    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] cipher_in;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic [127:0] plain_out;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;
    vec_t vecs [8];

    sifre_cozme_modulu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cipher_in (cipher_in),
        .key_in    (key_in),
        .busy      (busy),
        .done      (done),
        .plain_out (plain_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] xb, inv, s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            xb  = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (m_mul(xb, y[7:0]) == 8'h01) inv = y[7:0];
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                     ^ inv[(i + 7) % 8] ^ c[i];
            end
            sb[x]  = s;
            isb[s] = xb;
        end
    endtask

    function automatic logic [127:0] ref_decrypt(input logic [127:0] key, input logic [127:0] ct);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [7:0]  st [16];
        logic [7:0]  tmp [16];
        logic [7:0]  coef [4];
        logic [127:0] res;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = m_mul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int k = 0; k < 16; k++) st[k] = ct[127 - 8 * k -: 8];
        for (int rnd = 10; rnd >= 0; rnd--) begin
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        tmp[4 * ((c + r) % 4) + r] = st[4 * c + r];
                for (int k = 0; k < 16; k++) st[k] = isb[tmp[k]];
            end
            for (int k = 0; k < 16; k++) begin
                t = w[4 * rnd + k / 4];
                st[k] = st[k] ^ t[31 - 8 * (k % 4) -: 8];
            end
            if (rnd > 0 && rnd < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) begin
                        tmp[4 * c + r] = 8'h00;
                        for (int j = 0; j < 4; j++)
                            tmp[4 * c + r] = tmp[4 * c + r] ^ m_mul(coef[(j - r + 4) % 4], st[4 * c + j]);
                    end
                for (int k = 0; k < 16; k++) st[k] = tmp[k];
            end
        end
        for (int k = 0; k < 16; k++) res[127 - 8 * k -: 8] = st[k];
        return res;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts one block at the current sample point and returns at the sample where done is seen.
    task automatic run_block(input logic [127:0] k, input logic [127:0] c, input logic [127:0] exp,
                             input bit scramble, input int poke, input string nm);
        logic [127:0] held;
        int  n;
        bit  seen, hold_ok, busy_ok;
        held = plain_out;
        hold_ok = 1'b1;
        busy_ok = 1'b1;
        seen = 1'b0;
        n = 0;
        key_in = k;
        cipher_in = c;
        start = 1'b1;
        while (!seen && n < 40) begin
            step();
            n++;
            start = 1'b0;
            if (poke > 0 && n == poke) begin
                start = 1'b1;
                key_in = B_KEY;
                cipher_in = B_CT;
            end
            if (scramble) begin
                key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
                cipher_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (done) seen = 1'b1;
            else begin
                if (plain_out !== held) hold_ok = 1'b0;
                if (busy !== 1'b1) busy_ok = 1'b0;
            end
        end
        start = 1'b0;
        chk({nm, ".latency"}, 128'(n), 128'd21);
        chk({nm, ".plain"}, plain_out, exp);
        chk({nm, ".held"}, 128'(hold_ok), 128'd1);
        chk({nm, ".busy_during"}, 128'(busy_ok), 128'd1);
        chk({nm, ".busy_at_done"}, 128'(busy), 128'd0);
    endtask

    initial begin
        int extra;
        build_tables();
        vecs[0] = '{key: C1_KEY, ct: C1_CT, pt: C1_PT};
        vecs[1] = '{key: B_KEY, ct: B_CT, pt: B_PT};
        for (int i = 2; i < 8; i++) begin
            vecs[i].key = {$urandom(), $urandom(), $urandom(), $urandom()};
            vecs[i].ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
            vecs[i].pt  = ref_decrypt(vecs[i].key, vecs[i].ct);
        end

        // Reset with start held high: start must not be taken while rst_n=0.
        rst_n = 1'b0;
        start = 1'b1;
        key_in = C1_KEY;
        cipher_in = C1_CT;
        step();
        step();
        chk("reset.busy", 128'(busy), 128'd0);
        chk("reset.done", 128'(done), 128'd0);
        chk("reset.plain", plain_out, 128'd0);
        chk("reset.key_reg", dut.r_key, 128'd0);
        chk("reset.state_reg", dut.r_state, 128'd0);

        // First edge with rst_n=1 accepts start; C.1 with round-key-10 check.
        rst_n = 1'b1;
        step();
        start = 1'b0;
        chk("c1.first_start", 128'(busy), 128'd1);
        repeat (10) step();
        chk("c1.rk10", dut.r_key, C1_RK10);
        chk("c1.busy_mid", 128'(busy), 128'd1);
        chk("c1.plain_mid", plain_out, 128'd0);
        repeat (10) step();
        chk("c1.done", 128'(done), 128'd1);
        chk("c1.plain", plain_out, C1_PT);
        step();
        chk("c1.done_pulse", 128'(done), 128'd0);
        chk("c1.plain_hold", plain_out, C1_PT);

        // Table vectors, each started in the done cycle of the previous one.
        for (int i = 0; i < 8; i++) run_block(vecs[i].key, vecs[i].ct, vecs[i].pt, 1'b0, 0, $sformatf("vec%0d", i));

        // Back-to-back C.1 then Appendix B.
        run_block(C1_KEY, C1_CT, C1_PT, 1'b0, 0, "b2b_first");
        chk("b2b.done_at_handoff", 128'(done), 128'd1);
        run_block(B_KEY, B_CT, B_PT, 1'b0, 0, "b2b_second");

        // Start while busy: ignored, no queued block.
        step();
        step();
        run_block(C1_KEY, C1_CT, C1_PT, 1'b0, 5, "busy_start");
        extra = 0;
        repeat (30) begin
            step();
            if (done || busy) extra++;
        end
        chk("busy_start.no_queue", 128'(extra), 128'd0);

        // Reset pulse sampled at ROUND r=4 (16th edge after capture).
        key_in = C1_KEY;
        cipher_in = C1_CT;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (15) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midreset.busy", 128'(busy), 128'd0);
        chk("midreset.done", 128'(done), 128'd0);
        chk("midreset.plain", plain_out, 128'd0);
        extra = 0;
        repeat (30) begin
            step();
            if (done || busy || plain_out !== 128'd0) extra++;
        end
        chk("midreset.quiet", 128'(extra), 128'd0);
        run_block(C1_KEY, C1_CT, C1_PT, 1'b0, 0, "after_reset");

        // Input stability: inputs scrambled every cycle after capture.
        run_block(C1_KEY, C1_CT, C1_PT, 1'b1, 0, "stable_c1");
        run_block(vecs[2].key, vecs[2].ct, vecs[2].pt, 1'b1, 0, "stable_rand");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sifre_cozme_modulu.md
SIFRE_COZME_MODULU -- requirements
Module: sifre_cozme_modulu

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 The block SHALL have the following ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only while busy=0.
- cipher_in  input  128  ciphertext block.
- key_in  input  128  AES-128 cipher key.
- busy  output  1  high while a block is in progress.
- done  output  1  one-cycle pulse; plain_out is valid.
- plain_out  output  128  recovered plaintext; held until the next done.
REQ-003 Byte order SHALL follow FIPS-197: bits [127:120] are byte 0 (s0,0); bytes fill the state column-major.

Function
REQ-004 The block SHALL implement the AES-128 inverse cipher (FIPS-197 sec. 5.3), iteratively at one round per clock.
REQ-005 The state machine SHALL have the states IDLE, KEYEXP and ROUND; busy=1 exactly when the state is not IDLE.
REQ-006 IDLE behaviour: when start=1 at an edge, the block SHALL capture cipher_in and key_in, set rcnt=0 and go to KEYEXP.
REQ-007 KEYEXP SHALL take 10 edges, and each edge SHALL apply one forward key-schedule step, with Rcon = 01,02,04,08,10,20,40,80,1b,36.
REQ-008 On the 10th KEYEXP edge: the key register SHALL hold round key 10; the state register SHALL load cipher ^ rk10; rcnt SHALL be set to 9; the FSM SHALL go to ROUND.
REQ-009 ROUND SHALL take 10 edges, r = 9 down to 0.
- Key update: rk_(r) is derived from rk_(r+1) by the inverse schedule:
  - w3'=w3^w2, w2'=w2^w1, w1'=w1^w0.
  - w0'=w0^SubWord(RotWord(w3'))^Rcon_(r+1).
- State update: InvShiftRows, then InvSubBytes, then AddRoundKey(rk_r), then InvMixColumns.
- InvMixColumns SHALL be omitted when r=0.
REQ-010 On the r=0 edge, the block SHALL:
- register the result into plain_out;
- set done=1 for exactly one cycle;
- return to IDLE, with busy=0 in the same cycle as done.
REQ-011 Latency SHALL be fixed: done is high in the cycle after the 20th edge following the start-capture edge, regardless of data.
REQ-012 start while busy=1 SHALL be ignored, with no queuing and no effect on the block in progress.
REQ-013 start=1 in the cycle where done=1 SHALL be accepted, giving back-to-back throughput of one block per 21 cycles.
REQ-014 Input stability: cipher_in and key_in SHALL be sampled only on the capture edge; later changes SHALL have no effect.
REQ-015 The S-box and inverse S-box SHALL be combinational GF((2^4)^2) composite-field logic, not 256-entry tables; all arithmetic is in GF(2^8) modulo x^8+x^4+x^3+x+1.
REQ-016 plain_out SHALL change only on the done edge or on reset; it SHALL NOT show intermediate round values.

Reset
REQ-017 When rst_n=0 at an edge, the block SHALL set: state=IDLE, busy=0, done=0, plain_out=0, rcnt=0; internal state and key registers SHALL be cleared to 0.
REQ-018 Reset asserted mid-operation (in KEYEXP or ROUND) SHALL abort the block: no done pulse, and plain_out=0.
REQ-019 start sampled in the same cycle as rst_n=0 SHALL be ignored; the first accepted start is at the first edge with rst_n=1.

Verification
REQ-020 The bench SHALL check FIPS-197 C.1:
- Stimulus: key 000102030405060708090a0b0c0d0e0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a, start pulse.
- Response: after 20 edges, done=1 and plain_out=00112233445566778899aabbccddeeff.
- Internal check: the key register equals 13111d7fe3944a17f307a78b4d2b30c5 after the 10th KEYEXP edge.
REQ-021 The bench SHALL check FIPS-197 Appendix B:
- Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, cipher 3925841d02dc09fbdc118597196a0b32.
- Response: plain_out=3243f6a8885a308d313198a2e0370734.
REQ-022 The bench SHALL check start while busy:
- Stimulus: start the C.1 block, then assert start with the Appendix B inputs 5 cycles later.
- Response: exactly one done, with the C.1 plaintext; busy is unchanged.
REQ-023 The bench SHALL check back-to-back operation:
- Stimulus: start the Appendix B inputs in the done cycle of the C.1 block.
- Response: a second done exactly 21 cycles later, with the Appendix B plaintext; the first plain_out is held in between.
REQ-024 The bench SHALL check reset mid-operation:
- Stimulus: rst_n=0 for 1 cycle at ROUND r=4.
- Response: busy=0, done never pulses and plain_out=0; a new C.1 start then completes correctly.
REQ-025 The bench SHALL check input stability:
- Stimulus: change cipher_in and key_in every cycle after capture.
- Response: the result equals that of the captured values.
